// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers. Each channel produces a
// registered square wave plus a period-start tick intended for use as a clock enable.

module clk_div_chan #(
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 sync,
   input  logic                 wr,
   input  logic [DIV_WIDTH-1:0] wr_div,
   output logic                 pending,
   output logic                 clk_out,
   output logic                 tick
);
   localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DDIV = DIV_WIDTH'(DEFAULT_DIV);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, sh_q, sh_d, nxt;
   logic                 pend_q, pend_d, clko_q, clko_d, tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      clko_d = clko_q;
      tick_d = 1'b0;
      nxt    = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
      if (sync) begin
         cnt_d  = '0;
         clko_d = 1'b0;
         if (en) begin
            tick_d = 1'b1;
            if (pend_q) begin
               div_d  = sh_q;
               pend_d = 1'b0;
            end
         end
      end else if (en) begin
         cnt_d  = nxt;
         clko_d = (nxt >= (div_q >> 1));
         tick_d = (nxt == '0);
         if ((nxt == '0) && pend_q) begin
            div_d  = sh_q;
            pend_d = 1'b0;
         end
      end
      // A write lands after any wrap/sync apply so that the old shadow is consumed first.
      if (wr) begin
         if (en) begin
            sh_d   = wr_div;
            pend_d = 1'b1;
         end else begin
            div_d  = wr_div;
            cnt_d  = '0;
            clko_d = 1'b0;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         div_q  <= DDIV;
         sh_q   <= DDIV;
         pend_q <= 1'b0;
         clko_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         sh_q   <= sh_d;
         pend_q <= pend_d;
         clko_q <= clko_d;
         tick_q <= tick_d;
      end
   end

   assign pending = pend_q;
   assign clk_out = clko_q;
   assign tick    = tick_q;
endmodule

module clk_div_bank #(
   parameter int CHANNELS    = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 2,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  enable,
   input  logic                 sync,
   input  logic                 load,
   input  logic [CH_W-1:0]      load_ch,
   input  logic [DIV_WIDTH-1:0] load_div,
   output logic                 load_ack,
   output logic                 load_err,
   output logic [CHANNELS-1:0]  pending,
   output logic [CHANNELS-1:0]  clk_out,
   output logic [CHANNELS-1:0]  tick
);
   logic ok, ack_q, ack_d, err_q, err_d;
   logic [CHANNELS-1:0] wr;

   always_comb begin
      ok    = (load_div >= DIV_WIDTH'(2)) && (32'(load_ch) < CHANNELS);
      ack_d = load && ok;
      err_d = load && !ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
      end
   end

   assign load_ack = ack_q;
   assign load_err = err_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign wr[i] = ack_d && (load_ch == CH_W'(i));
      clk_div_chan #(.DIV_WIDTH(DIV_WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
         .clk    (clk),
         .reset  (reset),
         .en     (enable[i]),
         .sync   (sync),
         .wr     (wr[i]),
         .wr_div (load_div),
         .pending(pending[i]),
         .clk_out(clk_out[i]),
         .tick   (tick[i])
      );
   end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with three channels: vector table for start-up,
// ratio change and rejected writes, then hand-written sync/disable/max-ratio sequences.

module tb_clk_div_bank;
   localparam int CH = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [CH-1:0] enable;
   logic          sync, load;
   logic [1:0]    load_ch;
   logic [DW-1:0] load_div;
   logic          load_ack, load_err;
   logic [CH-1:0] pending, clk_out, tick;

   int total = 0;
   int bad   = 0;

   clk_div_bank #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sync(sync), .load(load),
      .load_ch(load_ch), .load_div(load_div), .load_ack(load_ack), .load_err(load_err),
      .pending(pending), .clk_out(clk_out), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  en;
      logic        ld;
      logic [1:0]  ch;
      logic [15:0] dv;
      logic [2:0]  co, tk, pd;
      logic        ack, err;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(logic [2:0] en, logic ld, logic [1:0] ch, logic [15:0] dv,
                               logic [2:0] co, logic [2:0] tk, logic [2:0] pd,
                               logic ack, logic err);
      vec_t v;
      v.en = en; v.ld = ld; v.ch = ch; v.dv = dv;
      v.co = co; v.tk = tk; v.pd = pd; v.ack = ack; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] bits(logic b0, logic b1, logic b2);
      return {b2, b1, b0};
   endfunction

   initial begin
      int lows, highs, ticks, ph1, d1;
      logic [2:0] eco, etk;

      // ch0 and ch1 at div 2; ch1 reprogrammed to 5 at cnt=1; then three rejected writes
      tbl[0]  = mk(3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 0);
      tbl[1]  = mk(3'b011, 0, 0, 0, 3'b000, 3'b011, 3'b000, 0, 0);
      tbl[2]  = mk(3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 0);
      tbl[3]  = mk(3'b011, 1, 1, 5, 3'b000, 3'b011, 3'b010, 1, 0);
      tbl[4]  = mk(3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b010, 0, 0);
      tbl[5]  = mk(3'b011, 0, 0, 0, 3'b000, 3'b011, 3'b000, 0, 0);
      tbl[6]  = mk(3'b011, 0, 0, 0, 3'b001, 3'b000, 3'b000, 0, 0);
      tbl[7]  = mk(3'b011, 0, 0, 0, 3'b010, 3'b001, 3'b000, 0, 0);
      tbl[8]  = mk(3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 0);
      tbl[9]  = mk(3'b011, 0, 0, 0, 3'b010, 3'b001, 3'b000, 0, 0);
      tbl[10] = mk(3'b011, 0, 0, 0, 3'b001, 3'b010, 3'b000, 0, 0);
      tbl[11] = mk(3'b011, 1, 0, 0, 3'b000, 3'b001, 3'b000, 0, 1);
      tbl[12] = mk(3'b011, 1, 2, 1, 3'b011, 3'b000, 3'b000, 0, 1);
      tbl[13] = mk(3'b011, 1, 3, 4, 3'b010, 3'b001, 3'b000, 0, 1);
      tbl[14] = mk(3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000, 0, 0);
      tbl[15] = mk(3'b011, 0, 0, 0, 3'b000, 3'b011, 3'b000, 0, 0);

      reset = 1'b1; enable = '0; sync = 0; load = 0; load_ch = 0; load_div = 0;
      #12;
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_ack_err", {30'd0, load_ack, load_err}, 0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         enable = tbl[i].en; load = tbl[i].ld; load_ch = tbl[i].ch; load_div = tbl[i].dv;
         step();
         chk($sformatf("v%0d_clk_out", i), 32'(clk_out), 32'(tbl[i].co));
         chk($sformatf("v%0d_tick", i), 32'(tick), 32'(tbl[i].tk));
         chk($sformatf("v%0d_pending", i), 32'(pending), 32'(tbl[i].pd));
         chk($sformatf("v%0d_ack", i), 32'(load_ack), 32'(tbl[i].ack));
         chk($sformatf("v%0d_err", i), 32'(load_err), 32'(tbl[i].err));
      end
      load = 0;

      // asynchronous reset while ch0 is high, checked before the next edge
      step();
      chk("pre_reset_clk_out", 32'(clk_out), 32'b001);
      reset = 1'b1;
      #1;
      chk("async_rst_clk_out", 32'(clk_out), 0);
      chk("async_rst_tick", 32'(tick), 0);
      chk("async_rst_pending", 32'(pending), 0);
      #2 reset = 1'b0;

      // program ch1=3, ch2=4 while disabled (immediate, load held on consecutive edges)
      enable = '0; load = 1; load_ch = 1; load_div = 3;
      step();
      chk("dis_load1_ack", 32'(load_ack), 1);
      chk("dis_load1_pending", 32'(pending), 0);
      load_ch = 2; load_div = 4;
      step();
      chk("dis_load2_ack", 32'(load_ack), 1);
      chk("dis_load2_pending", 32'(pending), 0);
      load = 0; enable = 3'b111;
      for (int i = 0; i < 5; i++) step();
      load = 1; load_ch = 1; load_div = 6;
      step();
      chk("pend_ch1", 32'(pending), 32'b010);
      // sync with a simultaneous write: sync applies 6, the new 3 stays pending
      sync = 1; load_div = 3;
      step();
      chk("sync_tick", 32'(tick), 32'b111);
      chk("sync_clk_out", 32'(clk_out), 0);
      chk("sync_pending", 32'(pending), 32'b010);
      sync = 0; load = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         ph1 = (k < 6) ? k : (k - 6) % 3;
         d1  = (k < 6) ? 6 : 3;
         eco = bits((k % 2) >= 1, ph1 >= d1 / 2, (k % 4) >= 2);
         etk = bits((k % 2) == 0, ph1 == 0, (k % 4) == 0);
         chk($sformatf("after_sync_k%0d_tick", k), 32'(tick), 32'(etk));
         chk($sformatf("after_sync_k%0d_clk_out", k), 32'(clk_out), 32'(eco));
         chk($sformatf("after_sync_k%0d_pending", k), 32'(pending), (k < 6) ? 32'b010 : 0);
      end

      // ch2 (div 4) frozen at cnt=2, then resumed from the held count
      step();
      step();
      chk("ch2_cnt2_high", 32'(clk_out[2]), 1);
      enable = 3'b011;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("frozen%0d_clk", i), 32'(clk_out[2]), 1);
         chk($sformatf("frozen%0d_tick", i), 32'(tick[2]), 0);
      end
      enable = 3'b111;
      step();
      chk("resume_cnt3", {30'd0, clk_out[2], tick[2]}, 32'b10);
      step();
      chk("resume_wrap", {30'd0, clk_out[2], tick[2]}, 32'b01);
      enable = 3'b011; load = 1; load_ch = 2; load_div = 6;
      step();
      chk("dis_load6_ack", 32'(load_ack), 1);
      chk("dis_load6_pending", 32'(pending[2]), 0);
      chk("dis_load6_clk", 32'(clk_out[2]), 0);
      load = 0; enable = 3'b111;
      for (int j = 1; j <= 6; j++) begin
         step();
         chk($sformatf("div6_j%0d", j), {30'd0, clk_out[2], tick[2]},
             {30'd0, (j >= 3 && j <= 5), (j == 6)});
      end

      // maximum ratio on ch0
      reset = 1'b1; #2 reset = 1'b0;
      enable = '0; load = 1; load_ch = 0; load_div = 16'hFFFF;
      step();
      chk("max_load_ack", 32'(load_ack), 1);
      load = 0; enable = 3'b001;
      lows = 0; highs = 0; ticks = 0;
      for (int n = 1; n <= 65535; n++) begin
         step();
         if (clk_out[0]) highs++; else lows++;
         if (tick[0]) ticks++;
         if (n == 65535) chk("max_wrap_tick", 32'(tick[0]), 1);
      end
      chk("max_lows", lows, 32767);
      chk("max_highs", highs, 32768);
      chk("max_ticks", ticks, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
